// File: rtl/fetch_npc_if.sv
// Fetch/ID boundary signals of the fetch_npc_unit: hazard, IM, comparator and
// decode inputs, plus the PC, IF/ID and redirect outputs.
interface fetch_npc_if;
    logic        stall;
    logic [31:0] if_instr;
    logic        cmp_eq;
    logic [2:0]  npc_op;
    logic [31:0] id_rs_val;

    logic [31:0] if_pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc8;
    logic        redirect;
    logic        target_misaligned;

    // master: the fetch unit itself
    modport master (
        input  stall, if_instr, cmp_eq, npc_op, id_rs_val,
        output if_pc, id_instr, id_pc, id_pc8, redirect, target_misaligned
    );

    // slave: the surrounding pipeline (hazard unit, IM, ID stage)
    modport slave (
        output stall, if_instr, cmp_eq, npc_op, id_rs_val,
        input  if_pc, id_instr, id_pc, id_pc8, redirect, target_misaligned
    );
endinterface

// File: rtl/fetch_npc_unit.sv
// Fetch PC register and IF/ID pipeline register with next-PC selection for a
// 5-stage MIPS pipeline using branch delay slots (no flush path).
module fetch_npc_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic            clk,
    input  logic            reset,
    fetch_npc_if.master     bus
);
    localparam int NUM_OPS = 8;

    logic [31:0] if_pc_reg;
    logic [31:0] id_instr_reg;
    logic [31:0] id_pc_reg;
    logic [31:0] pc_next;

    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] pc4;
    logic [31:0] b_tgt;
    logic [31:0] j_tgt;
    logic [31:0] r_tgt;
    logic [31:0] seq_pc;

    logic [NUM_OPS-1:0] taken_vec;
    logic [31:0]        tgt_vec [NUM_OPS];
    logic               taken;
    logic [31:0]        target;
    logic               redirect;

    assign imm16       = id_instr_reg[15:0];
    assign instr_index = id_instr_reg[25:0];
    assign pc4         = id_pc_reg + 32'd4;
    assign b_tgt       = pc4 + {{14{imm16[15]}}, imm16, 2'b00};
    assign j_tgt       = {pc4[31:28], instr_index, 2'b00};
    assign r_tgt       = bus.id_rs_val;
    assign seq_pc      = if_pc_reg + 32'd4;

    // Per-opcode decode table; reserved codes fall through as never-taken.
    generate
        for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_op
            if (gi == 1) begin : g_beq
                assign taken_vec[gi] = bus.cmp_eq;
                assign tgt_vec[gi]   = b_tgt;
            end else if (gi == 2) begin : g_bne
                assign taken_vec[gi] = ~bus.cmp_eq;
                assign tgt_vec[gi]   = b_tgt;
            end else if (gi == 3) begin : g_j
                assign taken_vec[gi] = 1'b1;
                assign tgt_vec[gi]   = j_tgt;
            end else if (gi == 4) begin : g_jr
                assign taken_vec[gi] = 1'b1;
                assign tgt_vec[gi]   = r_tgt;
            end else begin : g_seq
                assign taken_vec[gi] = 1'b0;
                assign tgt_vec[gi]   = seq_pc;
            end
        end
    endgenerate

    assign taken    = taken_vec[bus.npc_op];
    assign target   = tgt_vec[bus.npc_op];
    // A stalled branch must not redirect; it re-resolves once the stall lifts.
    assign redirect = taken & ~bus.stall;

    always_comb begin
        pc_next = seq_pc;
        if (redirect) begin
            pc_next = target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if_pc_reg    <= PC_RESET;
            id_instr_reg <= 32'd0;
            id_pc_reg    <= 32'd0;
        end else if (!bus.stall) begin
            if_pc_reg    <= pc_next;
            id_instr_reg <= bus.if_instr;
            id_pc_reg    <= if_pc_reg;
        end
    end

    assign bus.if_pc             = if_pc_reg;
    assign bus.id_instr          = id_instr_reg;
    assign bus.id_pc             = id_pc_reg;
    assign bus.id_pc8            = id_pc_reg + 32'd8;
    assign bus.redirect          = redirect;
    // Misaligned targets are still loaded; the exception logic decides the outcome.
    assign bus.target_misaligned = redirect & (target[1:0] != 2'b00);
endmodule

// File: tb/tb_fetch_npc_unit.sv
// Directed, table-driven bench for fetch_npc_unit: per-vector branch/jump
// resolution plus hand sequences for reset, stall and mid-stream reset.
module tb_fetch_npc_unit;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fetch_npc_if bus ();

    fetch_npc_unit #(.PC_RESET(32'h0000_3000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [2:0]  op;
        logic        cmp;
        logic [31:0] rs;
        logic        exp_red;
        logic        exp_mis;
        logic [31:0] exp_if_pc;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Place pc/instr in ID via a jr to pc followed by one sequential fetch of instr.
    task automatic load_id(input logic [31:0] pc, input logic [31:0] instr);
        bus.stall     = 1'b0;
        bus.npc_op    = 3'd4;
        bus.id_rs_val = pc;
        bus.if_instr  = 32'd0;
        tick();
        bus.npc_op    = 3'd0;
        bus.if_instr  = instr;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //           pc            instr         op   cmp   rs            red   mis   if_pc after edge
        vecs[0]  = '{32'h0000_3010, 32'h1000_0004, 3'd1, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0000_3024};
        vecs[1]  = '{32'h0000_3010, 32'h1000_0004, 3'd1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_3018};
        vecs[2]  = '{32'h0000_3010, 32'h1400_FFFF, 3'd2, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_3010};
        vecs[3]  = '{32'h0000_3010, 32'h1400_FFFF, 3'd2, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0000_3018};
        vecs[4]  = '{32'hFFFF_FFF8, 32'h1000_0002, 3'd1, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0000_0004};
        vecs[5]  = '{32'h0000_3000, 32'h0800_0C10, 3'd3, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_3040};
        vecs[6]  = '{32'h1FFF_FFFC, 32'h0800_0C10, 3'd3, 1'b1, 32'h0,        1'b1, 1'b0, 32'h2000_3040};
        vecs[7]  = '{32'h0000_3000, 32'h0060_0008, 3'd4, 1'b0, 32'h0000_3102, 1'b1, 1'b1, 32'h0000_3102};
        vecs[8]  = '{32'h0000_3000, 32'h0060_F809, 3'd4, 1'b1, 32'h0000_4000, 1'b1, 1'b0, 32'h0000_4000};
        vecs[9]  = '{32'h0000_3010, 32'h1000_0004, 3'd6, 1'b1, 32'h0000_5000, 1'b0, 1'b0, 32'h0000_3018};
        vecs[10] = '{32'h0000_3010, 32'h1000_0004, 3'd5, 1'b0, 32'h0000_5001, 1'b0, 1'b0, 32'h0000_3018};
        vecs[11] = '{32'h0000_3010, 32'h1000_0004, 3'd7, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0000_3018};
        vecs[12] = '{32'h0000_3010, 32'h1000_0004, 3'd0, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0000_3018};

        // Reset and three sequential cycles.
        reset         = 1'b1;
        bus.stall     = 1'b1;
        bus.if_instr  = 32'h1234_5678;
        bus.cmp_eq    = 1'b0;
        bus.npc_op    = 3'd0;
        bus.id_rs_val = 32'd0;
        tick();
        reset     = 1'b0;
        bus.stall = 1'b0;
        chk("rst_if_pc", bus.if_pc, 32'h0000_3000);
        chk("rst_id_instr", bus.id_instr, 32'h0);
        chk("rst_id_pc", bus.id_pc, 32'h0);
        chk("rst_id_pc8", bus.id_pc8, 32'h8);
        for (int i = 0; i < 3; i++) begin
            bus.if_instr = 32'h2000_0000 + 32'(i);
            tick();
            chk($sformatf("seq%0d_if_pc", i), bus.if_pc, 32'h0000_3004 + 32'(4 * i));
            chk($sformatf("seq%0d_id_pc", i), bus.id_pc, 32'h0000_3000 + 32'(4 * i));
            chk($sformatf("seq%0d_id_pc8", i), bus.id_pc8, 32'h0000_3008 + 32'(4 * i));
            chk($sformatf("seq%0d_id_instr", i), bus.id_instr, 32'h2000_0000 + 32'(i));
            $display("seq %0d: if_pc=%08h id_pc=%08h", i, bus.if_pc, bus.id_pc);
        end

        // Table: branch in ID, delay slot in IF, one resolving edge.
        for (int i = 0; i < 13; i++) begin
            load_id(vecs[i].pc, vecs[i].instr);
            bus.npc_op    = vecs[i].op;
            bus.cmp_eq    = vecs[i].cmp;
            bus.id_rs_val = vecs[i].rs;
            bus.if_instr  = 32'hA000_0000 + 32'(i);
            #1;
            chk($sformatf("v%0d_slot_pc", i), bus.if_pc, vecs[i].pc + 32'd4);
            chk($sformatf("v%0d_id_pc8", i), bus.id_pc8, vecs[i].pc + 32'd8);
            chk($sformatf("v%0d_redirect", i), 32'(bus.redirect), 32'(vecs[i].exp_red));
            chk($sformatf("v%0d_misaligned", i), 32'(bus.target_misaligned), 32'(vecs[i].exp_mis));
            tick();
            chk($sformatf("v%0d_if_pc", i), bus.if_pc, vecs[i].exp_if_pc);
            chk($sformatf("v%0d_id_pc", i), bus.id_pc, vecs[i].pc + 32'd4);
            chk($sformatf("v%0d_id_instr", i), bus.id_instr, 32'hA000_0000 + 32'(i));
            $display("vec %0d: op=%0d cmp=%0b redirect=%0b if_pc=%08h", i, vecs[i].op,
                     vecs[i].cmp, vecs[i].exp_red, bus.if_pc);
        end

        // Stalled beq: holds for two cycles, then resolves with post-stall cmp_eq.
        load_id(32'h0000_3010, 32'h1000_0004);
        bus.npc_op   = 3'd1;
        bus.if_instr = 32'hB000_0001;
        for (int i = 0; i < 2; i++) begin
            bus.stall  = 1'b1;
            bus.cmp_eq = (i == 0);
            #1;
            chk($sformatf("stall%0d_redirect", i), 32'(bus.redirect), 32'd0);
            tick();
            chk($sformatf("stall%0d_if_pc", i), bus.if_pc, 32'h0000_3014);
            chk($sformatf("stall%0d_id_pc", i), bus.id_pc, 32'h0000_3010);
            chk($sformatf("stall%0d_id_instr", i), bus.id_instr, 32'h1000_0004);
            $display("stall %0d: if_pc=%08h id_pc=%08h", i, bus.if_pc, bus.id_pc);
        end
        bus.stall  = 1'b0;
        bus.cmp_eq = 1'b1;
        #1;
        chk("unstall_redirect", 32'(bus.redirect), 32'd1);
        tick();
        chk("unstall_if_pc", bus.if_pc, 32'h0000_3024);
        chk("unstall_id_pc", bus.id_pc, 32'h0000_3014);
        chk("unstall_id_instr", bus.id_instr, 32'hB000_0001);
        $display("unstall: if_pc=%08h id_pc=%08h", bus.if_pc, bus.id_pc);

        // Reset mid-stream beats stall and a pending jump.
        load_id(32'h0000_5000, 32'h0800_0C10);
        bus.stall  = 1'b1;
        bus.npc_op = 3'd3;
        reset      = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_if_pc", bus.if_pc, 32'h0000_3000);
        chk("mrst_id_instr", bus.id_instr, 32'h0);
        chk("mrst_id_pc", bus.id_pc, 32'h0);
        bus.stall  = 1'b0;
        bus.npc_op = 3'd6;
        bus.cmp_eq = 1'b1;
        #1;
        chk("mrst_op6_redirect", 32'(bus.redirect), 32'd0);
        tick();
        chk("mrst_op6_if_pc", bus.if_pc, 32'h0000_3004);
        chk("mrst_op6_id_pc", bus.id_pc, 32'h0000_3000);
        $display("mid reset: if_pc=%08h id_pc=%08h", bus.if_pc, bus.id_pc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
